ssp_rx_timeout_sched: RTL and testbench
=======================================

# ssp_rx_timeout_sched

Scheduler and interrupt sequencer for the SSP receive-timeout watchdog. It generates the bit-period `IncRxTimeOut` pulse stream from the programmed clock divisors, and the master/slave reload pulses `MRxRT`/`SRxRT` from receive activity. It synchronises the RTIC clear, and turns the watchdog's `DataStp` level into the raw and masked receive-timeout interrupt. Sits in the SSPCLK domain between the register block, the Rx shifters and the watchdog.

## Interface
Parameters:
- `DIVW`, 8: width of `CPSDVSR` and `SCR`.

Ports:
- `SSPCLK` in 1: main SSP clock.
- `nSSPRST` in 1: reset, asynchronous, active-low; clock `SSPCLK`.
- `SSE` in 1: port enable.
- `MS` in 1: 0 = master, 1 = slave.
- `CPSDVSR` in DIVW: prescale divisor; values 0/1 are treated as 2; bit 0 is ignored.
- `SCR` in DIVW: serial clock rate.
- `RxDone` in 1: 1-cycle pulse when a received frame is written to the Rx FIFO.
- `RNESync` in 1: Rx FIFO not empty.
- `RTICWr` in 1: 1-cycle pulse on a write of 1 to `SSPICR.RTIC`.
- `RTIM` in 1: timeout interrupt mask (1 = enabled).
- `DataStp` in 1: watchdog idle-detected level.
- `RxTOTest` in 1: test force. Used only with `SSP_RXTO_TESTMODE_EN`; ignored otherwise.
- `IncRxTimeOut` out 1: one pulse per bit period.
- `MRxRT` out 1: master reload pulse.
- `SRxRT` out 1: slave reload pulse.
- `RTICSync` out 1: registered clear pulse.
- `RTRIS` out 1: raw timeout interrupt status.
- `SSPRTINTR` out 1: masked interrupt (`RTRIS & RTIM`).

## Operation
State machine, 2-bit encoding:
- IDLE (00): entered from reset, and from any state on `SSE=0`. Counters are cleared and `IncRxTimeOut` is 0.
- WAIT (01): `SSE=1` and `RNESync=0`. The prescaler is held at zero and the shadow divisors reload every cycle.
- RUN (11): `SSE=1` and `RNESync=1`. The prescaler counts.

Transitions:
- RUN -> WAIT on `RNESync=0`.
- WAIT -> RUN on `RNESync=1`.
- WAIT or RUN -> IDLE on `SSE=0`.

Prescaler:
- Stage A counts `0..CPSD_eff-1` and emits a tick at the terminal count. `CPSD_eff = max(2, CPSDVSR & ~1)`.
- Stage B counts ticks `0..SCR_sh` and pulses `IncRxTimeOut` at the terminal count with an A tick.
- The period is `D = CPSD_eff*(SCR_sh+1)` SSPCLK cycles, maximum 254*256.
- The shadows `CPSD_sh`/`SCR_sh` are captured in WAIT and at each `IncRxTimeOut`. A mid-period register write takes effect from the next period.

Reload:
- `MRxRT = RxDone & ~MS` and `SRxRT = RxDone & MS`, both registered.
- The same `RxDone` clears both prescaler stages in that cycle, so the next pulse follows `D` cycles of inactivity.
- `RxDone` in IDLE produces no reload pulse.

Interrupt:
- `RTICSync` is `RTICWr` registered.
- `RTRIS` sets on a `DataStp` rising edge, detected against a registered copy.
- `RTRIS` clears on `RTICSync`, on `DataStp=0`, or in IDLE.
- Simultaneous set and clear: clear wins.

## Timing
- Reset values of all outputs are 0. State is IDLE, counters are 0 and the `DataStp` history register is 0.
- The first `IncRxTimeOut` comes exactly `D` cycles after the first RUN cycle or after an `RxDone` cycle.
- Pulses are exactly one cycle wide. There is no pulse in the same cycle as `RxDone` or a WAIT entry.
- `MRxRT`/`SRxRT`/`RTICSync` have 1-cycle latency.
- `RTRIS` is high 1 cycle after `DataStp` rises and low 1 cycle after a clear condition.
- `SSPRTINTR` is combinational from `RTRIS` and `RTIM`.
- `SSE` falling: in IDLE the next cycle with all pulses suppressed. Asynchronous reset mid-period: the counters restart from zero and no partial pulse is issued.

## Configuration
- `SSP_RXTO_TESTMODE_EN` defined: while `RxTOTest=1` in RUN, `IncRxTimeOut` pulses every cycle (bypassing the prescaler) to shorten watchdog tests. `RxDone` still suppresses the pulse in its own cycle.
- Not defined: the `RxTOTest` port exists but is ignored, and the pulse stream is always prescaled.

## Test plan
- `CPSDVSR=2`, `SCR=3`, `SSE=1`, `RNESync` rising: first `IncRxTimeOut` 8 cycles after RUN entry, then every 8 cycles.
- `CPSDVSR=1` (treated as 2), `SCR=0`: pulse period 2; writing `SCR=4` mid-period gives one more 2-cycle period, then 10.
- `MS=0`, `RxDone` at cycle 5 of an 8-cycle period: `MRxRT` at cycle 6, `SRxRT` stays 0, next pulse 8 cycles after `RxDone`; repeat with `MS=1` -> `SRxRT` only.
- `DataStp` rises with `RTIM=1`: `RTRIS` and `SSPRTINTR` are 1 the next cycle; `RTICWr` pulse -> `RTICSync` the next cycle, `RTRIS` 0 one cycle after that; `RTIM=0` -> `SSPRTINTR` 0 while `RTRIS` is 1.
- `DataStp` rising in the same cycle as `RTICSync`: `RTRIS` remains 0. `SSE` dropped mid-period: no further pulses and `RTRIS` is 0.
- With `SSP_RXTO_TESTMODE_EN`: `RxTOTest=1` in RUN gives `IncRxTimeOut` high every cycle except `RxDone` cycles. Without the macro: the period is unchanged.

Source files
------------

// File: rtl/ssp_rx_timeout_sched.sv
// SSP receive-timeout scheduler: bit-period tick, reload pulses, RTI status.
// Optional SSP_RXTO_TESTMODE_EN: RxTOTest forces a tick every RUN cycle.
module ssp_rx_timeout_sched #(
   parameter int DIVW = 8
) (
   input  logic            SSPCLK,
   input  logic            nSSPRST,
   input  logic            SSE,
   input  logic            MS,
   input  logic [DIVW-1:0] CPSDVSR,
   input  logic [DIVW-1:0] SCR,
   input  logic            RxDone,
   input  logic            RNESync,
   input  logic            RTICWr,
   input  logic            RTIM,
   input  logic            DataStp,
   input  logic            RxTOTest,
   output logic            IncRxTimeOut,
   output logic            MRxRT,
   output logic            SRxRT,
   output logic            RTICSync,
   output logic            RTRIS,
   output logic            SSPRTINTR
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RUN  = 2'b11
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [DIVW-1:0] cpsd_in;
   logic [DIVW-1:0] cpsd_eff;
   logic [DIVW-1:0] cpsd_sh;
   logic [DIVW-1:0] scr_sh;
   logic [DIVW-1:0] cnt_a;
   logic [DIVW-1:0] cnt_b;
   logic            run;
   logic            stay;
   logic            term_a;
   logic            term_b;
   logic            due;
   logic            inc_q;
   logic            ds_q;
   logic            rt_set;
   logic            rt_clr;

   always_comb begin
      nxt = state;
      unique case (1'b1)
         !SSE:            nxt = IDLE;
         SSE && RNESync:  nxt = RUN;
         SSE && !RNESync: nxt = WAIT;
      endcase
   end

   // Even divisor only; anything below 2 runs at 2.
   assign cpsd_in  = {CPSDVSR[DIVW-1:1], 1'b0};
   assign cpsd_eff = (cpsd_in == '0) ? DIVW'(2) : cpsd_in;

   assign run    = (state == RUN);
   assign stay   = (nxt == RUN);
   assign term_a = (cnt_a == cpsd_sh - 1'b1);
   assign term_b = (cnt_b == scr_sh);
   assign due    = run && stay && !RxDone && term_a && term_b;

   always_ff @(posedge SSPCLK or negedge nSSPRST) begin
      if (!nSSPRST) begin
         cpsd_sh <= DIVW'(2);
         scr_sh  <= '0;
      end else if (!run || due) begin
         cpsd_sh <= cpsd_eff;
         scr_sh  <= SCR;
      end
   end

   // The RxDone cycle itself is count zero of the new period.
   always_ff @(posedge SSPCLK or negedge nSSPRST) begin
      if (!nSSPRST) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (!run || !stay) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (RxDone) begin
         cnt_a <= DIVW'(1);
         cnt_b <= '0;
      end else if (term_a) begin
         cnt_a <= '0;
         cnt_b <= term_b ? '0 : cnt_b + 1'b1;
      end else begin
         cnt_a <= cnt_a + 1'b1;
      end
   end

   assign rt_set = DataStp && !ds_q;
   assign rt_clr = RTICSync || !DataStp || !SSE || (state == IDLE);

   always_ff @(posedge SSPCLK or negedge nSSPRST) begin
      if (!nSSPRST) begin
         state    <= IDLE;
         inc_q    <= 1'b0;
         MRxRT    <= 1'b0;
         SRxRT    <= 1'b0;
         RTICSync <= 1'b0;
         ds_q     <= 1'b0;
         RTRIS    <= 1'b0;
      end else begin
         state    <= nxt;
         inc_q    <= due;
         MRxRT    <= RxDone && !MS && SSE && (state != IDLE);
         SRxRT    <= RxDone && MS && SSE && (state != IDLE);
         RTICSync <= RTICWr;
         ds_q     <= DataStp;
         if (rt_clr)
            RTRIS <= 1'b0;
         else if (rt_set)
            RTRIS <= 1'b1;
      end
   end

   assign SSPRTINTR = RTRIS && RTIM;

`ifdef SSP_RXTO_TESTMODE_EN
   logic unused_bits;
   assign unused_bits  = CPSDVSR[0];
   assign IncRxTimeOut = (inc_q || (run && RxTOTest)) && !RxDone;
`else
   logic [1:0] unused_bits;
   assign unused_bits  = {CPSDVSR[0], RxTOTest};
   assign IncRxTimeOut = inc_q && !RxDone;
`endif

endmodule

// File: tb/tb_ssp_rx_timeout_sched.sv
// Directed bench for ssp_rx_timeout_sched: tick timing, reloads, RTI status.
module tb_ssp_rx_timeout_sched;

   logic       SSPCLK = 1'b0;
   logic       nSSPRST = 1'b0;
   logic       SSE = 1'b0;
   logic       MS = 1'b0;
   logic [7:0] CPSDVSR = 8'd0;
   logic [7:0] SCR = 8'd0;
   logic       RxDone = 1'b0;
   logic       RNESync = 1'b0;
   logic       RTICWr = 1'b0;
   logic       RTIM = 1'b0;
   logic       DataStp = 1'b0;
   logic       RxTOTest = 1'b0;
   logic       IncRxTimeOut;
   logic       MRxRT;
   logic       SRxRT;
   logic       RTICSync;
   logic       RTRIS;
   logic       SSPRTINTR;

   int cyc = 0;
   int nchk = 0;
   int npass = 0;
   int nfail = 0;
   int pq[$];
   int mq[$];
   int sq[$];

   ssp_rx_timeout_sched #(.DIVW(8)) dut (
      .SSPCLK(SSPCLK),
      .nSSPRST(nSSPRST),
      .SSE(SSE),
      .MS(MS),
      .CPSDVSR(CPSDVSR),
      .SCR(SCR),
      .RxDone(RxDone),
      .RNESync(RNESync),
      .RTICWr(RTICWr),
      .RTIM(RTIM),
      .DataStp(DataStp),
      .RxTOTest(RxTOTest),
      .IncRxTimeOut(IncRxTimeOut),
      .MRxRT(MRxRT),
      .SRxRT(SRxRT),
      .RTICSync(RTICSync),
      .RTRIS(RTRIS),
      .SSPRTINTR(SSPRTINTR)
   );

   always #5 SSPCLK = ~SSPCLK;

   always @(posedge SSPCLK) cyc <= cyc + 1;

   always @(negedge SSPCLK) begin
      if (IncRxTimeOut === 1'b1) pq.push_back(cyc);
      if (MRxRT === 1'b1) mq.push_back(cyc);
      if (SRxRT === 1'b1) sq.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic go(input int t);
      while (cyc < t) begin
         @(posedge SSPCLK);
         #1;
      end
   endtask

   task automatic smp(input int t);
      go(t);
      @(negedge SSPCLK);
   endtask

   int c, c2, c3, d, g, c6, c7;

   initial begin
      #12;
      chk("reset_outputs",
          {IncRxTimeOut, MRxRT, SRxRT, RTICSync, RTRIS, SSPRTINTR}, 0);
      #1 nSSPRST = 1'b1;
      go(cyc + 2);

      // CPSDVSR=2, SCR=3: period 8 from first RUN cycle
      SSE = 1'b1;
      CPSDVSR = 8'd2;
      SCR = 8'd3;
      go(cyc + 3);
      c = cyc;
      RNESync = 1'b1;
      pq.delete();
      go(c + 30);
      chk("p8_first", qat(pq, 0), c + 9);
      chk("p8_second", qat(pq, 1), c + 17);
      chk("p8_third", qat(pq, 2), c + 25);
      chk("p8_count", pq.size(), 3);

      // CPSDVSR=1 -> 2, SCR=0, then SCR=4 mid-period
      RNESync = 1'b0;
      CPSDVSR = 8'd1;
      SCR = 8'd0;
      pq.delete();
      go(c + 33);
      chk("wait_quiet", pq.size(), 0);
      c2 = cyc;
      RNESync = 1'b1;
      go(c2 + 5);
      SCR = 8'd4;
      go(c2 + 30);
      chk("p2_a", qat(pq, 0), c2 + 3);
      chk("p2_b", qat(pq, 1), c2 + 5);
      chk("p2_last", qat(pq, 2), c2 + 7);
      chk("p10_a", qat(pq, 3), c2 + 17);
      chk("p10_b", qat(pq, 4), c2 + 27);
      chk("p2_p10_count", pq.size(), 5);

      // Reload pulses, master then slave
      RNESync = 1'b0;
      CPSDVSR = 8'd2;
      SCR = 8'd3;
      go(c2 + 33);
      c3 = cyc;
      RNESync = 1'b1;
      MS = 1'b0;
      pq.delete();
      mq.delete();
      sq.delete();
      go(c3 + 6);
      RxDone = 1'b1;
      go(c3 + 7);
      RxDone = 1'b0;
      go(c3 + 16);
      chk("m_reload_pulse", qat(pq, 0), c3 + 14);
      chk("m_reload_count", pq.size(), 1);
      chk("m_mrxrt", qat(mq, 0), c3 + 7);
      chk("m_mrxrt_count", mq.size(), 1);
      chk("m_srxrt_none", sq.size(), 0);
      pq.delete();
      mq.delete();
      sq.delete();
      MS = 1'b1;
      go(c3 + 17);
      RxDone = 1'b1;
      go(c3 + 18);
      RxDone = 1'b0;
      go(c3 + 27);
      chk("s_reload_pulse", qat(pq, 0), c3 + 25);
      chk("s_reload_count", pq.size(), 1);
      chk("s_srxrt", qat(sq, 0), c3 + 18);
      chk("s_mrxrt_none", mq.size(), 0);

      // Interrupt set, RTIC clear, mask
      d = cyc;
      RTIM = 1'b1;
      DataStp = 1'b1;
      smp(d + 1);
      chk("rtris_set", RTRIS, 1);
      chk("intr_set", SSPRTINTR, 1);
      go(d + 2);
      RTICWr = 1'b1;
      go(d + 3);
      RTICWr = 1'b0;
      smp(d + 3);
      chk("rticsync", RTICSync, 1);
      chk("rtris_before_clr", RTRIS, 1);
      smp(d + 4);
      chk("rtris_cleared", RTRIS, 0);
      chk("rticsync_width", RTICSync, 0);
      go(d + 5);
      DataStp = 1'b0;
      go(d + 6);
      DataStp = 1'b1;
      go(d + 7);
      RTIM = 1'b0;
      smp(d + 7);
      chk("rtris_masked", RTRIS, 1);
      chk("intr_masked", SSPRTINTR, 0);
      go(d + 8);
      RTIM = 1'b1;
      #1;
      chk("intr_unmasked", SSPRTINTR, 1);
      go(d + 9);
      DataStp = 1'b0;
      smp(d + 10);
      chk("rtris_datastp_low", RTRIS, 0);

      // Rise coincident with RTICSync: clear wins
      g = d + 12;
      go(g);
      RTICWr = 1'b1;
      go(g + 1);
      RTICWr = 1'b0;
      DataStp = 1'b1;
      smp(g + 1);
      chk("coinc_rticsync", RTICSync, 1);
      smp(g + 2);
      chk("coinc_rtris", RTRIS, 0);
      smp(g + 4);
      chk("coinc_rtris_later", RTRIS, 0);

      // SSE dropped mid-period
      go(g + 5);
      DataStp = 1'b0;
      RNESync = 1'b0;
      go(g + 8);
      c6 = cyc;
      RNESync = 1'b1;
      pq.delete();
      go(c6 + 10);
      DataStp = 1'b1;
      smp(c6 + 11);
      chk("sse_rtris_before", RTRIS, 1);
      go(c6 + 12);
      chk("sse_pulse_before", qat(pq, 0), c6 + 9);
      SSE = 1'b0;
      RxDone = 1'b1;
      MS = 1'b0;
      pq.delete();
      mq.delete();
      sq.delete();
      go(c6 + 13);
      RxDone = 1'b0;
      smp(c6 + 14);
      chk("sse_rtris_off", RTRIS, 0);
      go(c6 + 34);
      chk("sse_no_pulses", pq.size(), 0);
      chk("sse_no_reload", mq.size() + sq.size(), 0);

      // RxTOTest in RUN with RxDone at c7+5
      c7 = cyc;
      SSE = 1'b1;
      RxTOTest = 1'b1;
      MS = 1'b1;
      pq.delete();
      go(c7 + 5);
      RxDone = 1'b1;
      go(c7 + 6);
      RxDone = 1'b0;
      go(c7 + 15);
`ifdef SSP_RXTO_TESTMODE_EN
      chk("test_count", pq.size(), 13);
      chk("test_first", qat(pq, 0), c7 + 1);
      chk("test_skip_rxdone", qat(pq, 4), c7 + 6);
`else
      chk("notest_count", pq.size(), 1);
      chk("notest_pulse", qat(pq, 0), c7 + 13);
`endif
      RxTOTest = 1'b0;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
